// File: rtl/split_bus_arbiter_if.sv
// Bus-side signal bundle for the split bus arbiter: initiator requests,
// split-target handshake, grants, mux select and split status.
interface split_bus_arbiter_if;
  // Handshake: an initiator holds req_mx high for its whole transaction and owns
  // the bus only while grant_mx is high; the split target owns it while
  // split_grant is high and keeps split_req high until it is done.
  logic       req_m1;
  logic       req_m2;
  logic       split_req;
  logic       split_ack;
  logic       grant_m1;
  logic       grant_m2;
  logic       split_grant;
  logic [1:0] bus_sel;
  logic       split_pending;
  logic       split_owner;
  logic       split_timeout;

  modport slave (
    input  req_m1, req_m2, split_req, split_ack,
    output grant_m1, grant_m2, split_grant, bus_sel,
           split_pending, split_owner, split_timeout
  );

  modport master (
    output req_m1, req_m2, split_req, split_ack,
    input  grant_m1, grant_m2, split_grant, bus_sel,
           split_pending, split_owner, split_timeout
  );
endinterface

// File: rtl/split_bus_arbiter.sv
// Two-initiator round-robin bus arbiter with one outstanding split transaction,
// a return path for the split target and an optional split abandonment timer.
module split_bus_arbiter #(
  parameter int unsigned SPLIT_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  split_bus_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state
);

  localparam int unsigned CW         = (SPLIT_TIMEOUT == 0) ? 1 : $clog2(SPLIT_TIMEOUT + 1);
  localparam int unsigned LIMIT      = (SPLIT_TIMEOUT == 0) ? 0 : SPLIT_TIMEOUT - 1;
  localparam bit          TIMEOUT_EN = (SPLIT_TIMEOUT != 0);

  // Encoding matches bus_sel so the select is a straight copy of the state.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_M1    = 2'd1,
    GNT_M2    = 2'd2,
    GNT_SPLIT = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last;
  logic          pending;
  logic          owner;
  logic          timeout_pulse;
  logic          grant_m1_q;
  logic          grant_m2_q;
  logic          split_grant_q;
  logic [1:0]    bus_sel_q;
  logic [CW-1:0] cnt;

  logic          req1_ok;
  logic          req2_ok;
  logic          split_set;
  logic          split_done;
  logic          counting;
  logic          expire;

  always_comb begin
    req1_ok    = bus.req_m1 && !(pending && !owner);
    req2_ok    = bus.req_m2 && !(pending && owner);
    state_nxt  = state;
    unique case (state)
      IDLE: begin
        if (bus.split_req && pending)   state_nxt = GNT_SPLIT;
        else if (req1_ok && req2_ok)    state_nxt = last ? GNT_M1 : GNT_M2;
        else if (req1_ok)               state_nxt = GNT_M1;
        else if (req2_ok)               state_nxt = GNT_M2;
      end
      GNT_M1:    if (bus.split_ack || !bus.req_m1) state_nxt = IDLE;
      GNT_M2:    if (bus.split_ack || !bus.req_m2) state_nxt = IDLE;
      GNT_SPLIT: if (!bus.split_req)               state_nxt = IDLE;
    endcase
    split_set  = ((state == GNT_M1) || (state == GNT_M2)) && bus.split_ack;
    split_done = (state == GNT_SPLIT) && !bus.split_req;
    counting   = TIMEOUT_EN && pending && (state != GNT_SPLIT);
    // A split grant taken on the expiring edge beats the timeout.
    expire     = counting && (cnt == CW'(LIMIT)) && (state_nxt != GNT_SPLIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 1'b1;
      pending       <= 1'b0;
      owner         <= 1'b0;
      timeout_pulse <= 1'b0;
      grant_m1_q    <= 1'b0;
      grant_m2_q    <= 1'b0;
      split_grant_q <= 1'b0;
      bus_sel_q     <= 2'b00;
      cnt           <= '0;
    end else begin
      state         <= state_nxt;
      grant_m1_q    <= (state_nxt == GNT_M1);
      grant_m2_q    <= (state_nxt == GNT_M2);
      split_grant_q <= (state_nxt == GNT_SPLIT);
      bus_sel_q     <= state_nxt;
      timeout_pulse <= expire;
      if (state_nxt == GNT_M1 && state != GNT_M1) last <= 1'b0;
      if (state_nxt == GNT_M2 && state != GNT_M2) last <= 1'b1;
      // A freshly recorded split replaces any older one and restarts the timer.
      if (split_set) begin
        pending <= 1'b1;
        owner   <= (state == GNT_M2);
        cnt     <= '0;
      end else if (split_done || expire) begin
        pending <= 1'b0;
        cnt     <= '0;
      end else if (counting) begin
        cnt     <= cnt + 1'b1;
      end
    end
  end

  assign bus.grant_m1      = grant_m1_q;
  assign bus.grant_m2      = grant_m2_q;
  assign bus.split_grant   = split_grant_q;
  assign bus.bus_sel       = bus_sel_q;
  assign bus.split_pending = pending;
  assign bus.split_owner   = owner;
  assign bus.split_timeout = timeout_pulse;
  assign dbg_state         = state;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Self-checking bench for split_bus_arbiter: scripted scenarios push expected
// output vectors into a queue and pop them one clock later for comparison.
module tb_split_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  split_bus_arbiter_if bus();

  split_bus_arbiter #(.SPLIT_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Observed vector: {grant_m1, grant_m2, split_grant, bus_sel[1:0], split_pending, split_owner, split_timeout}
  logic [7:0] obs;
  assign obs = {bus.grant_m1, bus.grant_m2, bus.split_grant, bus.bus_sel,
                bus.split_pending, bus.split_owner, bus.split_timeout};

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] ev(input logic [1:0] sel, input logic pend, input logic own,
                                    input logic to);
    return {sel == 2'd1, sel == 2'd2, sel == 2'd3, sel, pend, own, to};
  endfunction

  task automatic drive(input logic r1, input logic r2, input logic sr, input logic sa,
                       input logic [7:0] e);
    bus.req_m1    = r1;
    bus.req_m2    = r2;
    bus.split_req = sr;
    bus.split_ack = sa;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    bus.req_m1 = 1'b0; bus.req_m2 = 1'b0; bus.split_req = 1'b0; bus.split_ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 8'h00) begin n_err++; $display("FAIL reset_out: got %b want %b", obs, 8'h00); end
    n_cmp++;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 8'h00) begin n_err++; $display("FAIL reset_idle: got %b want %b", obs, 8'h00); end
  endtask

  task automatic test_single();
    logic [7:0] e;
    logic [7:0] m;
    for (int i = 0; i < 12; i++) begin
      drive(i < 10, 1'b0, 1'b0, 1'b0, ev((i < 10) ? 2'd1 : 2'd0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      m = e[2] ? 8'hFF : 8'hFD;
      n_cmp++;
      if ((obs & m) !== (e & m)) begin
        n_err++; $display("FAIL single row %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_contention();
    logic [9:0] r1  = 10'b1101111000;
    logic [9:0] r2  = 10'b1111101110;
    logic [1:0] sel [10] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
    logic [7:0] e;
    logic [7:0] m;
    // Fresh reset so the first tie goes to m1.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(r1[9-i], r2[9-i], 1'b0, 1'b0, ev(sel[i], 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      m = e[2] ? 8'hFF : 8'hFD;
      n_cmp++;
      if ((obs & m) !== (e & m)) begin
        n_err++; $display("FAIL contention row %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_split_return();
    logic [10:0] r1   = 11'b00011000000;
    logic [10:0] r2   = 11'b11111111110;
    logic [10:0] sr   = 11'b00000011000;
    logic [10:0] sa   = 11'b00100001000;
    logic [10:0] pend = 11'b00111111000;
    logic [1:0]  sel [11] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0, 2'd2, 2'd0};
    logic [7:0] e;
    logic [7:0] m;
    for (int i = 0; i < 11; i++) begin
      drive(r1[10-i], r2[10-i], sr[10-i], sa[10-i], ev(sel[i], pend[10-i], 1'b1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      m = e[2] ? 8'hFF : 8'hFD;
      n_cmp++;
      if ((obs & m) !== (e & m)) begin
        n_err++; $display("FAIL split_return row %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_spurious();
    int len1;
    int len2;
    logic [1:0] s;
    logic [7:0] e;
    logic [7:0] m;
    len1 = int'($urandom_range(2, 6));
    len2 = int'($urandom_range(2, 6));
    for (int i = 0; i < 20; i++) begin
      if (i < len1)                        s = 2'd1;
      else if (i > len1 && i <= len1+len2) s = 2'd2;
      else                                 s = 2'd0;
      // split_ack is also pulsed while idle, where it must be ignored.
      drive(i < len1, (i > len1) && (i <= len1 + len2), 1'b1, i >= len1 + len2 + 2,
            ev(s, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      m = e[2] ? 8'hFF : 8'hFD;
      n_cmp++;
      if ((obs & m) !== (e & m)) begin
        n_err++; $display("FAIL spurious row %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [1:0] s;
    logic       p;
    logic       t;
    logic [7:0] e;
    logic [7:0] m;
    for (int i = 0; i < 12; i++) begin
      s = (i == 0 || i == 10) ? 2'd1 : 2'd0;
      p = (i >= 1 && i <= 8);
      t = (i == 9);
      drive(i < 11, 1'b0, 1'b0, i == 1, ev(s, p, 1'b0, t));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      m = e[2] ? 8'hFF : 8'hFD;
      n_cmp++;
      if ((obs & m) !== (e & m)) begin
        n_err++; $display("FAIL timeout row %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_simultaneous_reset();
    logic [4:0] r2  = 5'b10000;
    logic [4:0] sr  = 5'b00011;
    logic [4:0] sa  = 5'b01000;
    logic [4:0] pd  = 5'b01111;
    logic [1:0] sel [5] = '{2'd2, 2'd0, 2'd0, 2'd3, 2'd3};
    logic [7:0] e;
    logic [7:0] m;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, r2[4-i], sr[4-i], sa[4-i], ev(sel[i], pd[4-i], 1'b1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      m = e[2] ? 8'hFF : 8'hFD;
      n_cmp++;
      if ((obs & m) !== (e & m)) begin
        n_err++; $display("FAIL simultaneous row %0d: got %b want %b", i, obs, e);
      end
    end
    // Asynchronous reset in the middle of the split grant.
    #2; rst_n = 1'b0; #1;
    n_cmp++;
    if (obs !== 8'h00) begin n_err++; $display("FAIL reset_mid_out: got %b want %b", obs, 8'h00); end
    n_cmp++;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_mid_state: got %0d want 0", dbg_state); end
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 8'h00) begin n_err++; $display("FAIL reset_hold: got %b want %b", obs, 8'h00); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // The lost split must not be granted; the first tie after reset goes to m1.
      drive(i == 1, i == 1, i == 0, 1'b0, ev((i == 1) ? 2'd1 : 2'd0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      m = e[2] ? 8'hFF : 8'hFD;
      n_cmp++;
      if ((obs & m) !== (e & m)) begin
        n_err++; $display("FAIL after_reset row %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_split_return();
    test_spurious();
    test_timeout();
    test_simultaneous_reset();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover_queue: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/split_bus_arbiter.md
# split_bus_arbiter

Central arbiter for the serial bus. It shares the bus between two initiator ports (m1, m2) and one split-capable target port. It records a split when the owning initiator's transaction is suspended by `split_ack`, and later hands the bus to the split target when that target raises `split_req`. Its outputs drive the initiator ports' grants, the split target port's `arbiter_grant`, and the bus mux select.

## Interface
- `SPLIT_TIMEOUT`, default 255: cycles a split may stay pending before it is abandoned; 0 disables the timeout.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_m1`  in  1  m1 bus request, held high for the whole transaction.
- `req_m2`  in  1  m2 bus request, same rules as `req_m1`.
- `split_req`  in  1  split target requests the bus to finish a split transaction.
- `split_ack`  in  1  addressed target splits the current initiator transaction.
- `grant_m1`  out  1  m1 owns the bus.
- `grant_m2`  out  1  m2 owns the bus.
- `split_grant`  out  1  split target owns the bus.
- `bus_sel`  out  2  mux select: 00 none, 01 m1, 10 m2, 11 split target.
- `split_pending`  out  1  a split transaction is outstanding.
- `split_owner`  out  1  initiator of the outstanding split (0 = m1, 1 = m2); valid while `split_pending`.
- `split_timeout`  out  1  one-cycle pulse when a pending split is abandoned.

## Operation
- FSM states: IDLE, GNT_M1, GNT_M2, GNT_SPLIT. All grants and `bus_sel` decode from the state register (Moore); they are never asserted combinationally from inputs.
- A master is *blocked* while `split_pending` is set and `split_owner` names it. Its request is ignored until the split completes or times out.
- IDLE, evaluated in priority order:
  - (1) `split_req && split_pending` → GNT_SPLIT.
  - (2) Unblocked requests from both masters → round-robin: grant the master not granted most recently (`last` register).
  - (3) A single unblocked request → that master.
  - (4) Otherwise stay in IDLE.
- GNT_Mx:
  - `split_ack` high → set `split_pending`, set `split_owner` = x, go to IDLE.
  - Else `req_mx` low → go to IDLE.
  - `split_ack` wins if `req_mx` drops in the same cycle. `last` updates to x on entry.
- GNT_SPLIT:
  - `split_req` low → go to IDLE and clear `split_pending`, unblocking the owner.
  - `split_ack` is ignored in this state.
- `split_req` while `split_pending` = 0 is ignored; the bus is never granted to it.
- `split_ack` is ignored in IDLE.
- Timeout counter:
  - Width: `$clog2(SPLIT_TIMEOUT+1)`.
  - Clears when `split_pending` is set.
  - Increments each cycle `split_pending` is high and the state is not GNT_SPLIT.
  - On reaching `SPLIT_TIMEOUT`: clear `split_pending`, pulse `split_timeout`.
  - The counter freezes in GNT_SPLIT.
  - If IDLE would take GNT_SPLIT in the same cycle the count expires, the grant wins and there is no timeout.
  - When `SPLIT_TIMEOUT` = 0 the counter is held at 0 and never fires.

## Timing
- Reset (async, immediate): state IDLE; `grant_m1`, `grant_m2`, `split_grant` = 0; `bus_sel` = 00; `split_pending` = 0; `split_owner` = 0; `split_timeout` = 0; counter = 0; `last` = m2, so m1 wins the first tie.
- Request sampled high at edge N in IDLE → grant high after edge N (1-cycle latency).
- Release: request sampled low at edge N → grant low after edge N. There is at least one IDLE cycle between any two ownerships (bus turnaround); back-to-back grants are not allowed.
- `split_ack` sampled at edge N in GNT_Mx → grant low and `split_pending` high after edge N.
- `split_timeout`: high for exactly one cycle, the cycle after the expiring edge. `split_pending` drops at the same edge.
- Reset asserted mid-grant: all grants drop immediately; any pending split is lost.
- Exactly one of `grant_m1`, `grant_m2`, `split_grant` is high at any time, or none.

## Test plan
- **Single request:** `req_m1` high 10 cycles → `grant_m1` high cycles 1–10 after the request, `bus_sel` = 01, then 00 one cycle after the drop.
- **Contention:** `req_m1` and `req_m2` held together → grants alternate m1, m2, m1 as each releases, with one IDLE cycle between each.
- **Split and return:**
  - m2 granted; `split_ack` pulse → `grant_m2` low, `split_pending` = 1, `split_owner` = 1.
  - With `req_m2` still high it stays ungranted while `req_m1` is granted.
  - `split_req` after m1 releases → `split_grant` = 1, `bus_sel` = 11.
  - `split_req` low → `split_pending` = 0, and m2 is granted on its next request.
- **Spurious split request:** `split_req` with no pending split → no `split_grant` for 20 cycles; masters are still served.
- **Timeout:** `SPLIT_TIMEOUT` = 8, split set, no `split_req` → `split_timeout` pulses exactly 8 cycles after `split_pending` rose, and the owner becomes grantable.
- **Simultaneous and reset:**
  - `split_ack` and request drop in the same cycle → split recorded.
  - `rst_n` low during GNT_SPLIT → all outputs at reset values immediately.
